// File: rtl/gray_step_arbiter_if.sv
// Purpose : bundles the requester and gray-counter handshake signals of gray_step_arbiter.
// Latency : none, this file holds only wiring.
// Backpress: none, Req is a level held by the requester until its Done pulse.
// Ports (slave = arbiter side):
//   Req[1:0], Len0/Len1[3:0]  requester inputs to the arbiter
//   CntValue[2:0], CntOvf     gray counter output and sticky overflow, into the arbiter
//   Grant, Done, Busy         arbiter status outputs
//   CntClr, CntEn             counter control outputs
//   Result[2:0], Wrapped      captured result of the last completed burst
interface gray_step_arbiter_if;
    logic [1:0] Req;
    logic [3:0] Len0;
    logic [3:0] Len1;
    logic [1:0] Grant;
    logic [1:0] Done;
    logic       Busy;
    logic       CntClr;
    logic       CntEn;
    logic [2:0] CntValue;
    logic       CntOvf;
    logic [2:0] Result;
    logic       Wrapped;

    // Requester and counter side of the link.
    modport master (
        output Req, Len0, Len1, CntValue, CntOvf,
        input  Grant, Done, Busy, CntClr, CntEn, Result, Wrapped
    );

    // Arbiter side of the link.
    modport slave (
        input  Req, Len0, Len1, CntValue, CntOvf,
        output Grant, Done, Busy, CntClr, CntEn, Result, Wrapped
    );
endinterface

// File: rtl/gray_step_arbiter.sv
// Purpose : round-robin owner of a shared gray counter. It clears the counter, steps it
//           Len times for the winning requester, then captures the final value and overflow.
// Latency : grant is 1 cycle after the request in IDLE. A burst takes L+2 cycles
//           (CLEAR, L RUN cycles, DONE) and is followed by at least 1 IDLE cycle.
// Backpress: Req is a held level. Dropping the winner's Req during CLEAR or RUN aborts
//           the burst with no Done pulse.
// Ports   : Clk, Reset (synchronous, active-high), bus (gray_step_arbiter_if.slave).
module gray_step_arbiter (
    input  logic                  Clk,
    input  logic                  Reset,
    gray_step_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       winner_q, winner_d;
    logic       last_q, last_d;      // requester served most recently
    logic [4:0] steps_q, steps_d;    // RUN cycles still to go, 1..16
    logic [2:0] result_q, result_d;
    logic       wrapped_q, wrapped_d;

    logic       pick;
    logic [3:0] win_len;
    logic [1:0] win_onehot;

    // Round-robin pick. A lone requester always wins. When both request,
    // the requester that was not served last wins.
    always_comb begin
        pick = ~last_q;
        if (bus.Req == 2'b01) begin
            pick = 1'b0;
        end else if (bus.Req == 2'b10) begin
            pick = 1'b1;
        end
        win_len = pick ? bus.Len1 : bus.Len0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            winner_q  <= 1'b0;
            last_q    <= 1'b1;
            steps_q   <= 5'd0;
            result_q  <= 3'd0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            steps_q   <= steps_d;
            result_q  <= result_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        steps_d   = steps_q;
        result_d  = result_q;
        wrapped_d = wrapped_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Req != 2'b00) begin
                    winner_d = pick;
                    // A length field of zero stands for the full 16 steps.
                    steps_d  = (win_len == 4'd0) ? 5'd16 : {1'b0, win_len};
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!bus.Req[winner_q]) begin
                    state_d = S_IDLE;
                    last_d  = winner_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.Req[winner_q]) begin
                    // An aborted burst still counts as served for fairness.
                    state_d = S_IDLE;
                    last_d  = winner_q;
                end else begin
                    steps_d = steps_q - 5'd1;
                    if (steps_q == 5'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The counter has taken exactly L steps since CLEAR.
                result_d  = bus.CntValue;
                wrapped_d = bus.CntOvf;
                last_d    = winner_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign win_onehot = winner_q ? 2'b10 : 2'b01;

    assign bus.Grant   = (state_q != S_IDLE) ? win_onehot : 2'b00;
    assign bus.Done    = (state_q == S_DONE) ? win_onehot : 2'b00;
    assign bus.Busy    = (state_q != S_IDLE);
    // The counter clears together with the arbiter while Reset is high.
    assign bus.CntClr  = (state_q == S_CLEAR) || Reset;
    assign bus.CntEn   = (state_q == S_RUN) && !Reset;
    assign bus.Result  = result_q;
    assign bus.Wrapped = wrapped_q;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Purpose : self-checking bench for gray_step_arbiter with a gray counter model attached.
// Latency : bursts are observed from the first Grant cycle until Grant returns to 00.
// Backpress: requesters drop Req on their Done pulse, or hold it to exercise round-robin.
module tb_gray_step_arbiter;

    logic Clk;
    logic Reset;
    gray_step_arbiter_if bus();

    gray_step_arbiter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Environment: 3-bit binary counter with a sticky overflow, presented in gray code.
    logic [2:0] cnt_q;
    logic       ovf_q;
    always @(posedge Clk) begin
        if (bus.CntClr) begin
            cnt_q <= 3'd0;
            ovf_q <= 1'b0;
        end else if (bus.CntEn) begin
            if (cnt_q == 3'd7) ovf_q <= 1'b1;
            cnt_q <= cnt_q + 3'd1;
        end
    end
    assign bus.CntValue = cnt_q ^ (cnt_q >> 1);
    assign bus.CntOvf   = ovf_q;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic       model_last;
    logic [2:0] model_res;
    logic       model_wr;

    // Measurements taken by observe().
    logic [1:0] o_g, o_done;
    int o_wait, o_gcyc, o_en, o_clr, o_dpos, o_odd;
    bit o_tmo;

    function automatic logic [2:0] gray_of(input int l);
        int m;
        m = l % 8;
        return 3'(m ^ (m >> 1));
    endfunction

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Watches one burst and records what happened. It drops requester bits named in
    // drop_mask on their Done pulse. It returns at the negedge of the first cycle
    // after Grant falls.
    task automatic observe(input logic [1:0] drop_mask, input bit scramble);
        o_g = 2'b00; o_done = 2'b00; o_wait = 0; o_gcyc = 0; o_en = 0;
        o_clr = 0; o_dpos = -1; o_odd = 0; o_tmo = 0;
        while (bus.Grant == 2'b00 && o_wait < 40) begin
            o_wait++;
            cyc();
        end
        if (bus.Grant == 2'b00) begin
            o_tmo = 1;
            return;
        end
        o_g = bus.Grant;
        while (bus.Grant != 2'b00 && o_gcyc < 40) begin
            o_gcyc++;
            if (bus.Grant !== o_g) o_odd++;
            if (bus.Busy !== 1'b1) o_odd++;
            if (bus.CntEn === 1'b1) o_en++;
            if (bus.CntClr === 1'b1) o_clr++;
            if (bus.Done != 2'b00) begin
                o_done = o_done | bus.Done;
                o_dpos = o_gcyc;
                bus.Req = bus.Req & ~(bus.Done & drop_mask);
            end
            if (scramble) begin
                bus.Len0 = 4'($urandom);
                bus.Len1 = 4'($urandom);
            end
            cyc();
        end
        if (bus.Grant != 2'b00) o_tmo = 1;
        if (bus.Busy !== 1'b0) o_odd++;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.Req = 2'b00; bus.Len0 = 4'd0; bus.Len1 = 4'd0;
        repeat (3) cyc();
        checks++; if (bus.Grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", bus.Grant); end
        checks++; if (bus.Done !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", bus.Done); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
        checks++; if (bus.CntEn !== 1'b0) begin errors++; $display("FAIL reset_cnten got %b exp 0", bus.CntEn); end
        checks++; if (bus.CntClr !== 1'b1) begin errors++; $display("FAIL reset_cntclr got %b exp 1", bus.CntClr); end
        checks++; if (bus.Result !== 3'b000) begin errors++; $display("FAIL reset_result got %b exp 000", bus.Result); end
        checks++; if (bus.Wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %b exp 0", bus.Wrapped); end
        Reset = 1'b0;
        cyc();
        checks++; if (bus.CntClr !== 1'b0) begin errors++; $display("FAIL idle_cntclr got %b exp 0", bus.CntClr); end
        model_last = 1'b1; model_res = 3'd0; model_wr = 1'b0;
    endtask

    task automatic test_single();
        bus.Req = 2'b01; bus.Len0 = 4'd3;
        observe(2'b11, 1'b0);
        checks++; if (o_tmo) begin errors++; $display("FAIL single_timeout got 1 exp 0"); end
        checks++; if (o_g !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", o_g); end
        checks++; if (o_gcyc != 5) begin errors++; $display("FAIL single_len got %0d exp 5", o_gcyc); end
        checks++; if (o_en != 3) begin errors++; $display("FAIL single_cnten got %0d exp 3", o_en); end
        checks++; if (o_clr != 1) begin errors++; $display("FAIL single_cntclr got %0d exp 1", o_clr); end
        checks++; if (o_done !== 2'b01 || o_dpos != 5) begin errors++; $display("FAIL single_done got %b@%0d exp 01@5", o_done, o_dpos); end
        checks++; if (bus.Result !== 3'b010 || bus.Wrapped !== 1'b0) begin errors++; $display("FAIL single_result got %b/%b exp 010/0", bus.Result, bus.Wrapped); end
        checks++; if (o_odd != 0) begin errors++; $display("FAIL single_busy got %0d exp 0", o_odd); end
        model_last = 1'b0; model_res = 3'b010; model_wr = 1'b0;
        bus.Req = 2'b00;
    endtask

    task automatic test_wrap();
        bus.Req = 2'b10; bus.Len1 = 4'd0;
        observe(2'b11, 1'b1);
        checks++; if (o_g !== 2'b10 || o_tmo) begin errors++; $display("FAIL wrap16_grant got %b exp 10", o_g); end
        checks++; if (o_en != 16) begin errors++; $display("FAIL wrap16_cnten got %0d exp 16", o_en); end
        checks++; if (bus.Result !== 3'b000 || bus.Wrapped !== 1'b1) begin errors++; $display("FAIL wrap16_result got %b/%b exp 000/1", bus.Result, bus.Wrapped); end
        bus.Req = 2'b10; bus.Len1 = 4'd9;
        observe(2'b11, 1'b1);
        checks++; if (o_en != 9 || o_tmo) begin errors++; $display("FAIL wrap9_cnten got %0d exp 9", o_en); end
        checks++; if (bus.Result !== 3'b001 || bus.Wrapped !== 1'b1) begin errors++; $display("FAIL wrap9_result got %b/%b exp 001/1", bus.Result, bus.Wrapped); end
        model_last = 1'b1; model_res = 3'b001; model_wr = 1'b1;
        bus.Req = 2'b00;
    endtask

    task automatic test_contention();
        Reset = 1'b1;
        repeat (2) cyc();
        Reset = 1'b0;
        model_last = 1'b1;
        bus.Req = 2'b11; bus.Len0 = 4'd2; bus.Len1 = 4'd5;
        observe(2'b11, 1'b0);
        checks++; if (o_g !== 2'b01 || o_done !== 2'b01) begin errors++; $display("FAIL cont_first got %b/%b exp 01/01", o_g, o_done); end
        checks++; if (bus.Result !== 3'b011) begin errors++; $display("FAIL cont_first_result got %b exp 011", bus.Result); end
        observe(2'b11, 1'b0);
        checks++; if (o_wait != 1) begin errors++; $display("FAIL cont_idle got %0d exp 1", o_wait); end
        checks++; if (o_g !== 2'b10 || o_done !== 2'b10) begin errors++; $display("FAIL cont_second got %b/%b exp 10/10", o_g, o_done); end
        checks++; if (bus.Result !== 3'b111 || bus.Wrapped !== 1'b0) begin errors++; $display("FAIL cont_second_result got %b/%b exp 111/0", bus.Result, bus.Wrapped); end
        model_last = 1'b1; model_res = 3'b111; model_wr = 1'b0;
        bus.Req = 2'b00;
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        int l0, l1, l;
        bus.Req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            l0 = $urandom_range(0, 15); l1 = $urandom_range(0, 15);
            bus.Len0 = 4'(l0); bus.Len1 = 4'(l1);
            exp_g = model_last ? 2'b01 : 2'b10;
            l = model_last ? l0 : l1;
            if (l == 0) l = 16;
            observe((k == 3) ? 2'b11 : 2'b00, 1'b1);
            checks++; if (o_g !== exp_g || o_tmo) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", k, o_g, exp_g); end
            checks++; if (bus.Result !== gray_of(l) || bus.Wrapped !== (l >= 8)) begin errors++; $display("FAIL fair_result%0d got %b/%b exp %b/%b", k, bus.Result, bus.Wrapped, gray_of(l), l >= 8); end
            model_last = ~model_last;
            model_res = gray_of(l); model_wr = (l >= 8);
        end
        bus.Req = 2'b00;
    endtask

    task automatic test_abort();
        int t, en, dn;
        bus.Req = 2'b01; bus.Len0 = 4'd8;
        t = 0; en = 0; dn = 0;
        while (bus.Grant == 2'b00 && t < 20) begin t++; cyc(); end
        checks++; if (bus.Grant !== 2'b01) begin errors++; $display("FAIL abort_grant got %b exp 01", bus.Grant); end
        // CLEAR cycle, then three RUN cycles; Req drops in the third.
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.Req = 2'b00;
            if (bus.CntEn === 1'b1) en++;
            if (bus.Done != 2'b00) dn++;
            if (k < 3) cyc();
        end
        cyc();
        checks++; if (en != 3) begin errors++; $display("FAIL abort_runs got %0d exp 3", en); end
        checks++; if (bus.Grant !== 2'b00 || bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b/%b exp 00/0", bus.Grant, bus.Busy); end
        for (int k = 0; k < 3; k++) begin
            if (bus.Done != 2'b00) dn++;
            cyc();
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", dn); end
        checks++; if (bus.Result !== model_res || bus.Wrapped !== model_wr) begin errors++; $display("FAIL abort_keep got %b/%b exp %b/%b", bus.Result, bus.Wrapped, model_res, model_wr); end
        model_last = 1'b0;
        // Requester 0 was served last, even though aborted, so requester 1 wins now.
        bus.Req = 2'b11; bus.Len0 = 4'd1; bus.Len1 = 4'd1;
        observe(2'b11, 1'b0);
        checks++; if (o_g !== 2'b10 || o_tmo) begin errors++; $display("FAIL abort_lastserved got %b exp 10", o_g); end
        checks++; if (bus.Result !== 3'b001 || bus.Wrapped !== 1'b0) begin errors++; $display("FAIL abort_next_result got %b/%b exp 001/0", bus.Result, bus.Wrapped); end
        model_last = 1'b1; model_res = 3'b001; model_wr = 1'b0;
        bus.Req = 2'b00;
    endtask

    task automatic test_reset_mid_run();
        int t;
        bus.Req = 2'b10; bus.Len1 = 4'd6;
        t = 0;
        while (bus.Grant == 2'b00 && t < 20) begin t++; cyc(); end
        cyc(); cyc();
        checks++; if (bus.CntEn !== 1'b1) begin errors++; $display("FAIL rst_run_pre got %b exp 1", bus.CntEn); end
        Reset = 1'b1;
        #1;
        checks++; if (bus.CntClr !== 1'b1) begin errors++; $display("FAIL rst_run_cntclr got %b exp 1", bus.CntClr); end
        cyc();
        checks++; if (bus.Grant !== 2'b00 || bus.Done !== 2'b00 || bus.Busy !== 1'b0 || bus.CntEn !== 1'b0) begin errors++; $display("FAIL rst_run_outputs got %b/%b/%b/%b exp 00/00/0/0", bus.Grant, bus.Done, bus.Busy, bus.CntEn); end
        checks++; if (bus.Result !== 3'b000 || bus.Wrapped !== 1'b0 || bus.CntClr !== 1'b1) begin errors++; $display("FAIL rst_run_state got %b/%b/%b exp 000/0/1", bus.Result, bus.Wrapped, bus.CntClr); end
        Reset = 1'b0; bus.Req = 2'b00;
        cyc();
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 2'b00 || bus.CntClr !== 1'b0) begin errors++; $display("FAIL rst_run_after got %b/%b/%b exp 0/00/0", bus.Busy, bus.Done, bus.CntClr); end
        model_last = 1'b1; model_res = 3'd0; model_wr = 1'b0;
        bus.Req = 2'b11; bus.Len0 = 4'd5; bus.Len1 = 4'($urandom);
        observe(2'b11, 1'b0);
        checks++; if (o_g !== 2'b01 || o_en != 5 || o_tmo) begin errors++; $display("FAIL rst_run_next got %b/%0d exp 01/5", o_g, o_en); end
        checks++; if (bus.Result !== 3'b111 || bus.Wrapped !== 1'b0) begin errors++; $display("FAIL rst_run_next_result got %b/%b exp 111/0", bus.Result, bus.Wrapped); end
        model_last = 1'b0; model_res = 3'b111; model_wr = 1'b0;
        bus.Req = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0] pat, exp_g;
        logic       w;
        int l0, l1, l;
        for (int k = 0; k < 20; k++) begin
            pat = 2'($urandom_range(1, 3));
            l0 = $urandom_range(0, 15); l1 = $urandom_range(0, 15);
            bus.Req = pat; bus.Len0 = 4'(l0); bus.Len1 = 4'(l1);
            w = (pat == 2'b01) ? 1'b0 : (pat == 2'b10) ? 1'b1 : ~model_last;
            exp_g = w ? 2'b10 : 2'b01;
            l = w ? l1 : l0;
            if (l == 0) l = 16;
            observe(2'b11, 1'($urandom_range(0, 1)));
            checks++; if (o_tmo || o_wait != 1) begin errors++; $display("FAIL rnd%0d_start got tmo=%0d wait=%0d exp 0/1", k, o_tmo, o_wait); end
            checks++; if (o_g !== exp_g) begin errors++; $display("FAIL rnd%0d_grant got %b exp %b", k, o_g, exp_g); end
            checks++; if (o_gcyc != l + 2 || o_en != l || o_clr != 1) begin errors++; $display("FAIL rnd%0d_timing got %0d/%0d/%0d exp %0d/%0d/1", k, o_gcyc, o_en, o_clr, l + 2, l); end
            checks++; if (o_done !== exp_g || o_dpos != l + 2) begin errors++; $display("FAIL rnd%0d_done got %b@%0d exp %b@%0d", k, o_done, o_dpos, exp_g, l + 2); end
            checks++; if (bus.Result !== gray_of(l) || bus.Wrapped !== (l >= 8)) begin errors++; $display("FAIL rnd%0d_result got %b/%b exp %b/%b", k, bus.Result, bus.Wrapped, gray_of(l), l >= 8); end
            checks++; if (o_odd != 0) begin errors++; $display("FAIL rnd%0d_busy got %0d exp 0", k, o_odd); end
            model_last = w; model_res = gray_of(l); model_wr = (l >= 8);
        end
        bus.Req = 2'b00;
    endtask

    initial begin
        Reset = 1'b1;
        bus.Req = 2'b00; bus.Len0 = 4'd0; bus.Len1 = 4'd0;
        @(negedge Clk);
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_fairness();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
